exu_branch_predict_unit: RTL and testbench

- Successor to the EXU branch block: resolves jump/branch in EX against the prediction that travelled down the pipeline.
- Redirects the front end only on a mispredict; the old block redirected on every taken jump.
- Owns a parametrised bimodal branch history table (BHT) of 2-bit saturating counters. IF reads it combinationally; EX updates it at resolve.
- Redirect and flush outputs are registered, giving one cycle of latency, and the unit suppresses the wrong-path instruction that arrives in the shadow cycle.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/bht_counter_array.sv | 42 ++++
 rtl/exu_branch_predict_unit.sv | 120 ++++++++++++
 tb/tb_exu_branch_predict_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch-prediction types: 2-bit BHT counter encoding, default table size
// and the PC-to-index helper used by exu_branch_predict_unit.
package branch_pkg;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_SNT = 2'b00;
  localparam bht_cnt_t CNT_WNT = 2'b01;
  localparam bht_cnt_t CNT_WT  = 2'b10;
  localparam bht_cnt_t CNT_ST  = 2'b11;

  localparam int unsigned BHT_ENTRIES_DEF = 16;

  // entries is a power of two, so masking the shifted PC selects the index field
  function automatic int unsigned bht_idx(input logic [63:0] pc,
                                          input int unsigned idx_lo,
                                          input int unsigned entries);
    return 32'((pc >> idx_lo) & 64'(entries - 1));
  endfunction

endpackage

// File: rtl/bht_counter_array.sv
// Bimodal table of 2-bit saturating counters: one combinational read port
// (taken bit only) and one synchronous saturating update port.
module bht_counter_array
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES   = BHT_ENTRIES_DEF,
  parameter int unsigned IDX_W     = $clog2(ENTRIES),
  parameter bht_cnt_t    CNT_RESET = CNT_WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_cnt_t cnt_q [ENTRIES];
  bht_cnt_t upd_d;

  // Read sees the registered value, so a same-cycle update is not forwarded
  assign rd_taken_o = cnt_q[rd_idx_i][1];

  always_comb begin
    upd_d = cnt_q[upd_idx_i];
    if (upd_taken_i) begin
      if (upd_d != CNT_ST) upd_d = upd_d + 2'd1;
    end else begin
      if (upd_d != CNT_SNT) upd_d = upd_d - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_d;
    end
  end

endmodule

// File: rtl/exu_branch_predict_unit.sv
// EX-stage branch resolve against the travelling prediction; redirects only on
// mispredict and owns the BHT. Optional perf counters with `define BRANCH_PERF_EN.
module exu_branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DEF,
  parameter int unsigned BHT_IDX_LO  = 2,
  parameter bht_cnt_t    CNT_RESET   = CNT_WNT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            exu_valid,
  input  logic [XLEN-1:0] exu_pc,
  input  logic [XLEN-1:0] exu_rs1_data,
  input  logic [XLEN-1:0] exu_csr_rs_data,
  input  logic [XLEN-1:0] exu_imm,
  input  logic            exu_alu_less,
  input  logic            exu_alu_zero,
  input  logic            exu_jump,
  input  logic            exu_pc_plus_imm,
  input  logic            exu_rs1_plus_imm,
  input  logic            exu_csr_plus_imm,
  input  logic            exu_cmp_eq,
  input  logic            exu_cmp_neq,
  input  logic            exu_cmp_ge,
  input  logic            exu_cmp_lt,
  input  logic            exu_pred_taken,
  input  logic [XLEN-1:0] exu_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if,
  output logic            flush_id,
  output logic            flush_ex
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     perf_branch_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [XLEN-1:0]  base, target, redirect_pc_d, redirect_pc_q;
  logic             taken, cond, live, mispred, bht_upd;
  logic             redirect_valid_q, shadow_q;

  assign if_idx = IDX_W'(bht_idx(64'(if_pc),  BHT_IDX_LO, BHT_ENTRIES));
  assign ex_idx = IDX_W'(bht_idx(64'(exu_pc), BHT_IDX_LO, BHT_ENTRIES));

  always_comb begin
    base = ({XLEN{exu_pc_plus_imm}}  & exu_pc)
         | ({XLEN{exu_rs1_plus_imm}} & exu_rs1_data)
         | ({XLEN{exu_csr_plus_imm}} & exu_csr_rs_data);
    target = base + exu_imm;
    taken  = exu_jump & ~((exu_cmp_eq  & ~exu_alu_zero) | (exu_cmp_neq & exu_alu_zero)
                        | (exu_cmp_ge  &  exu_alu_less) | (exu_cmp_lt  & ~exu_alu_less));
    cond   = exu_cmp_eq | exu_cmp_neq | exu_cmp_ge | exu_cmp_lt;
    // The instruction right behind a redirect is wrong-path and must not act
    live    = exu_valid & ~shadow_q;
    mispred = live & ((taken != exu_pred_taken)
                    | (taken & exu_pred_taken & (target != exu_pred_target)));
    bht_upd = live & exu_jump & cond;
    redirect_pc_d = redirect_pc_q;
    if (mispred) redirect_pc_d = taken ? target : exu_pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      shadow_q         <= 1'b0;
    end else begin
      redirect_valid_q <= mispred;
      redirect_pc_q    <= redirect_pc_d;
      shadow_q         <= mispred;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if       = redirect_valid_q;
  assign flush_id       = redirect_valid_q;
  assign flush_ex       = redirect_valid_q;

  bht_counter_array #(
    .ENTRIES   (BHT_ENTRIES),
    .IDX_W     (IDX_W),
    .CNT_RESET (CNT_RESET)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (if_idx),
    .rd_taken_o  (if_pred_taken),
    .upd_en_i    (bht_upd),
    .upd_idx_i   (ex_idx),
    .upd_taken_i (taken)
  );

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branch_q, perf_mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (bht_upd) perf_branch_q  <= perf_branch_q + 32'd1;
      if (mispred) perf_mispred_q <= perf_mispred_q + 32'd1;
    end
  end

  assign perf_branch_cnt  = perf_branch_q;
  assign perf_mispred_cnt = perf_mispred_q;
`endif

endmodule

// File: tb/tb_exu_branch_predict_unit.sv
// Scoreboard bench for exu_branch_predict_unit: a reference model pushes the
// expected post-edge state per driven instruction; it is popped and compared after the edge.
module tb_exu_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic        exu_valid = 1'b0;
  logic [31:0] exu_pc = '0, exu_rs1_data = '0, exu_csr_rs_data = '0, exu_imm = '0;
  logic        exu_alu_less = 1'b0, exu_alu_zero = 1'b0, exu_jump = 1'b0;
  logic        exu_pc_plus_imm = 1'b0, exu_rs1_plus_imm = 1'b0, exu_csr_plus_imm = 1'b0;
  logic        exu_cmp_eq = 1'b0, exu_cmp_neq = 1'b0, exu_cmp_ge = 1'b0, exu_cmp_lt = 1'b0;
  logic        exu_pred_taken = 1'b0;
  logic [31:0] exu_pred_target = '0;
  logic        redirect_valid, flush_if, flush_id, flush_ex;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branch_cnt, perf_mispred_cnt;
`endif

  always #5 clk = ~clk;

  exu_branch_predict_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (16),
    .BHT_IDX_LO  (2),
    .CNT_RESET   (2'b01)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .exu_valid        (exu_valid),
    .exu_pc           (exu_pc),
    .exu_rs1_data     (exu_rs1_data),
    .exu_csr_rs_data  (exu_csr_rs_data),
    .exu_imm          (exu_imm),
    .exu_alu_less     (exu_alu_less),
    .exu_alu_zero     (exu_alu_zero),
    .exu_jump         (exu_jump),
    .exu_pc_plus_imm  (exu_pc_plus_imm),
    .exu_rs1_plus_imm (exu_rs1_plus_imm),
    .exu_csr_plus_imm (exu_csr_plus_imm),
    .exu_cmp_eq       (exu_cmp_eq),
    .exu_cmp_neq      (exu_cmp_neq),
    .exu_cmp_ge       (exu_cmp_ge),
    .exu_cmp_lt       (exu_cmp_lt),
    .exu_pred_taken   (exu_pred_taken),
    .exu_pred_target  (exu_pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .flush_ex         (flush_ex)
`ifdef BRANCH_PERF_EN
    ,
    .perf_branch_cnt  (perf_branch_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1, csr, imm;
    logic        less, zero, jump;
    logic [2:0]  sel;   // {csr, rs1, pc}
    logic [3:0]  cmp;   // {lt, ge, neq, eq}
    logic        pred;
    logic [31:0] ptgt;
  } op_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        pt;
    logic [31:0] nbr, nmis;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          m_bht[16];
  logic        m_shadow;
  logic [31:0] m_rpc, m_nbr, m_nmis;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_shadow = 1'b0;
    m_rpc    = '0;
    m_nbr    = '0;
    m_nmis   = '0;
  endtask

  function automatic op_t idle();
    op_t o;
    o.valid = 1'b0; o.pc = 32'h8000_0000; o.rs1 = '0; o.csr = '0; o.imm = '0;
    o.less = 1'b0; o.zero = 1'b0; o.jump = 1'b0; o.sel = 3'b000; o.cmp = 4'b0000;
    o.pred = 1'b0; o.ptgt = '0;
    return o;
  endfunction

  function automatic op_t br(input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] cmp,
                             input logic zero, input logic less, input logic pred,
                             input logic [31:0] ptgt);
    op_t o = idle();
    o.valid = 1'b1; o.pc = pc; o.imm = imm; o.cmp = cmp; o.zero = zero; o.less = less;
    o.jump = 1'b1; o.sel = 3'b001; o.pred = pred; o.ptgt = ptgt;
    return o;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
    chk("redirect_pc", redirect_pc, e.rpc);
    chk("flush_if", {31'd0, flush_if}, {31'd0, e.rv});
    chk("flush_id", {31'd0, flush_id}, {31'd0, e.rv});
    chk("flush_ex", {31'd0, flush_ex}, {31'd0, e.rv});
    chk("pred_post", {31'd0, if_pred_taken}, {31'd0, e.pt});
`ifdef BRANCH_PERF_EN
    chk("perf_branch", perf_branch_cnt, e.nbr);
    chk("perf_mispred", perf_mispred_cnt, e.nmis);
`endif
  endtask

  task automatic run_op(input op_t o);
    exp_t        e;
    logic [31:0] base, tgt;
    logic        tk, cnd, lv, mis;
    int          idx;
    exu_valid = o.valid; exu_pc = o.pc; exu_rs1_data = o.rs1; exu_csr_rs_data = o.csr;
    exu_imm = o.imm; exu_alu_less = o.less; exu_alu_zero = o.zero; exu_jump = o.jump;
    exu_pc_plus_imm = o.sel[0]; exu_rs1_plus_imm = o.sel[1]; exu_csr_plus_imm = o.sel[2];
    exu_cmp_eq = o.cmp[0]; exu_cmp_neq = o.cmp[1]; exu_cmp_ge = o.cmp[2]; exu_cmp_lt = o.cmp[3];
    exu_pred_taken = o.pred; exu_pred_target = o.ptgt;
    if_pc = o.pc;
    idx = int'(o.pc[5:2]);
    #1;
    chk("pred_pre", {31'd0, if_pred_taken}, {31'd0, (m_bht[idx] >= 2)});

    base = (o.sel[0] ? o.pc : 32'd0) | (o.sel[1] ? o.rs1 : 32'd0) | (o.sel[2] ? o.csr : 32'd0);
    tgt  = base + o.imm;
    tk   = o.jump && !((o.cmp[0] && !o.zero) || (o.cmp[1] && o.zero) ||
                       (o.cmp[2] && o.less)  || (o.cmp[3] && !o.less));
    cnd  = |o.cmp;
    lv   = o.valid && !m_shadow;
    mis  = lv && ((tk != o.pred) || (tk && o.pred && (tgt != o.ptgt)));
    if (mis) m_rpc = tk ? tgt : o.pc + 32'd4;
    m_shadow = mis;
    if (lv && o.jump && cnd) begin
      if (tk && m_bht[idx] < 3) m_bht[idx]++;
      else if (!tk && m_bht[idx] > 0) m_bht[idx]--;
      m_nbr++;
    end
    if (mis) m_nmis++;
    e.rv = mis; e.rpc = m_rpc; e.pt = (m_bht[idx] >= 2); e.nbr = m_nbr; e.nmis = m_nmis;
    sb.push_back(e);

    @(posedge clk);
    #1;
    check_pop();
    exu_valid = 1'b0;
  endtask

  task automatic sweep_bht(input string tag);
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'h8000_0000 + 32'(i * 4);
      #1;
      chk(tag, {31'd0, if_pred_taken}, {31'd0, (m_bht[i] >= 2)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    op_t o;
    model_reset();
    rst_n = 1'b0;
    if_pc = 32'h8000_0000;
    #1;
    chk("rst_pred_80000000", {31'd0, if_pred_taken}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_flush_ex", {31'd0, flush_ex}, 32'd0);
    sweep_bht("rst_bht");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken, predicted not-taken; then predicted correctly twice (saturation)
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b1, 1'b0, 1'b0, '0));
    run_op(idle());
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b1, 1'b0, 1'b1, 32'h8000_0030));
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b1, 1'b0, 1'b1, 32'h8000_0030));

    // JALR with odd sum and wrong predicted target
    o = idle();
    o.valid = 1'b1; o.pc = 32'h8000_0008; o.rs1 = 32'h8000_1001; o.imm = 32'd4;
    o.jump = 1'b1; o.sel = 3'b010; o.pred = 1'b1; o.ptgt = 32'h8000_0000;
    run_op(o);
    run_op(idle());

    // Mispredict, then a mispredicting BNE in the shadow cycle, then a non-jump at that PC
    run_op(br(32'h8000_0020, 32'h20, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h8000_0040));
    run_op(br(32'h8000_0040, 32'h8, 4'b0010, 1'b0, 1'b0, 1'b0, '0));
    o = idle(); o.valid = 1'b1; o.pc = 32'h8000_0040;
    run_op(o);

    // Walk idx 4 counter down 11 -> 10 -> 01
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h8000_0030));
    run_op(idle());
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h8000_0030));
    run_op(idle());

    // BGE taken backward, BLT not taken
    run_op(br(32'h8000_0014, 32'hFFFF_FFF8, 4'b0100, 1'b0, 1'b0, 1'b0, '0));
    run_op(idle());
    run_op(br(32'h8000_0018, 32'h40, 4'b1000, 1'b0, 1'b0, 1'b0, '0));

    // CSR-based jump predicted correctly
    o = idle();
    o.valid = 1'b1; o.pc = 32'h8000_001C; o.csr = 32'h100; o.imm = 32'h10;
    o.jump = 1'b1; o.sel = 3'b100; o.pred = 1'b1; o.ptgt = 32'h110;
    run_op(o);

    // JAL taken/predicted but wrong target
    o = idle();
    o.valid = 1'b1; o.pc = 32'h8000_0100; o.imm = 32'h40;
    o.jump = 1'b1; o.sel = 3'b001; o.pred = 1'b1; o.ptgt = 32'h8000_0200;
    run_op(o);
    run_op(idle());

    // Non-jump predicted taken at top of address space: pc+4 wraps
    o = idle(); o.valid = 1'b1; o.pc = 32'hFFFF_FFFC; o.pred = 1'b1; o.ptgt = 32'h1234;
    run_op(o);
    run_op(idle());

    // Jump with no base select: target = imm
    o = idle(); o.valid = 1'b1; o.pc = 32'h8000_0030; o.imm = 32'h500; o.jump = 1'b1;
    run_op(o);
    run_op(idle());

    // Reset asserted while redirect_valid is high
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b1, 1'b0, 1'b0, '0));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_redirect_pc", redirect_pc, 32'd0);
    chk("rst_mid_flush_if", {31'd0, flush_if}, 32'd0);
    chk("rst_mid_flush_id", {31'd0, flush_id}, 32'd0);
`ifdef BRANCH_PERF_EN
    chk("rst_mid_perf_branch", perf_branch_cnt, 32'd0);
    chk("rst_mid_perf_mispred", perf_mispred_cnt, 32'd0);
`endif
    sweep_bht("rst_mid_bht");
    rst_n = 1'b1;
    // Shadow must be cleared by reset: this mispredict is live
    run_op(br(32'h8000_0010, 32'h20, 4'b0001, 1'b1, 1'b0, 1'b0, '0));
    run_op(idle());

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
